// File: rtl/id_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_ctrl_pkg
//  Purpose  : Shared LC-3b decode-stage types for the ID hazard controller:
//             register-address type, hazard FSM state enum and the R7
//             constant used as the forced TRAP/JSR link destination.
//  Revision : 1.0 - initial release
// ============================================================================
package id_hazard_ctrl_pkg;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [0:0] {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } lc3b_hz_state;

    localparam lc3b_reg R7 = 3'b111;

endpackage
`default_nettype wire

// File: rtl/id_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_ctrl_if
//  Purpose  : Bundle of decode-stage, write-back and control signals seen by
//             the ID hazard controller.
//  Ports    : master - drives the ID/WB/control inputs, observes strobes,
//                      scoreboard flags and performance counters
//             slave  - the hazard controller side
//  Revision : 1.0 - initial release
// ============================================================================
interface id_hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    import id_hazard_ctrl_pkg::*;

    logic              id_valid;
    lc3b_reg           src1;
    logic              src1_used;
    lc3b_reg           src2;
    logic              src2_used;
    lc3b_reg           dest;
    logic              dest_used;
    logic              trapsel;
    logic              flush;
    logic              pipe_freeze;
    logic              wb_load;
    lc3b_reg           wb_dest;
    logic              id_issue;
    logic              id_stall;
    logic              id_bubble;
    logic [7:0]        busy;
    logic              sb_err;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] stall_events;

    modport master (
        output id_valid, src1, src1_used, src2, src2_used, dest, dest_used,
               trapsel, flush, pipe_freeze, wb_load, wb_dest,
        input  id_issue, id_stall, id_bubble, busy, sb_err,
               stall_cycles, stall_events
    );

    modport slave (
        input  id_valid, src1, src1_used, src2, src2_used, dest, dest_used,
               trapsel, flush, pipe_freeze, wb_load, wb_dest,
        output id_issue, id_stall, id_bubble, busy, sb_err,
               stall_cycles, stall_events
    );

endinterface
`default_nettype wire

// File: rtl/id_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hz_scoreboard
//  Purpose  : Eight per-register in-flight write counters. An issuing writer
//             increments its destination, a WB write decrements its target.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             inc_en/inc_idx   - count one more pending write
//             dec_en/dec_idx   - retire one pending write
//             busy[i]          - cnt[i] != 0
//             full[i]          - cnt[i] == all-ones
//             err              - sticky underflow/overflow flag
//  Revision : 1.0 - initial release
// ============================================================================
module hz_scoreboard
    import id_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_en,
    input  lc3b_reg    inc_idx,
    input  logic       dec_en,
    input  lc3b_reg    dec_idx,
    output logic [7:0] busy,
    output logic [7:0] full,
    output logic       err
);

    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [7:0] w_err;
    logic       r_err;

    for (genvar i = 0; i < 8; i++) begin : g_reg
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = inc_en && (inc_idx == lc3b_reg'(i));
        assign w_dec = dec_en && (dec_idx == lc3b_reg'(i));

        // A simultaneous inc and dec cancel, so they never count as an error
        // even at the counter limits.
        assign w_err[i] = (w_inc && !w_dec && (r_cnt == c_MAX))
                        | (w_dec && !w_inc && (r_cnt == '0));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec && (r_cnt != c_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign busy[i] = (r_cnt != '0);
        assign full[i] = (r_cnt == c_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (|w_err) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_ctrl
//  Purpose  : LC-3b ID-stage hazard controller. Stalls ID while a source
//             operand has an outstanding write (or the destination counter
//             is full), drives the ID hold / ID-EX bubble / issue strobes and
//             keeps saturating stall performance counters.
//  Ports    : clk   - pipeline clock
//             reset - synchronous active-high reset
//             hz    - id_hazard_ctrl_if slave (ID fields, WB write, flush,
//                     freeze in; strobes, busy, sb_err, counters out)
//  Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    id_hazard_ctrl_if.slave   hz
);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_STALL = 1'b1;

    lc3b_reg           w_eff_dest;
    logic [7:0]        w_busy;
    logic [7:0]        w_full;
    logic              w_sb_err;
    logic              w_hazard;
    logic              w_issue;
    logic              w_stall;
    logic              w_bubble;
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              w_stall_event;
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_stall_events;

    assign w_eff_dest = hz.trapsel ? R7 : hz.dest;

    // The full-counter term is a structural stall: one more in-flight write
    // to that register could not be tracked.
    assign w_hazard = hz.id_valid &&
                      ((hz.src1_used && w_busy[hz.src1]) ||
                       (hz.src2_used && w_busy[hz.src2]) ||
                       (hz.dest_used && w_full[w_eff_dest]));

    // Freeze already holds every stage, so none of the strobes may act.
    always_comb begin
        w_issue  = 1'b0;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        if (hz.pipe_freeze) begin
            w_issue = 1'b0;
        end else if (hz.flush) begin
            w_bubble = 1'b1;
        end else if (w_hazard) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end else begin
            w_issue = hz.id_valid;
        end
    end

    hz_scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk     (clk),
        .reset   (reset),
        .inc_en  (w_issue && hz.dest_used),
        .inc_idx (w_eff_dest),
        .dec_en  (hz.wb_load),
        .dec_idx (hz.wb_dest),
        .busy    (w_busy),
        .full    (w_full),
        .err     (w_sb_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (!hz.pipe_freeze) begin
            if (hz.flush) begin
                w_state_nxt = c_ST_RUN;
            end else if (w_hazard) begin
                w_state_nxt = c_ST_STALL;
            end else begin
                w_state_nxt = c_ST_RUN;
            end
        end
    end

    assign w_stall_event = (r_state == c_ST_RUN) && w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_RUN;
            r_stall_cycles <= '0;
            r_stall_events <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_stall_event && (r_stall_events != '1)) begin
                r_stall_events <= r_stall_events + 1'b1;
            end
        end
    end

    assign hz.id_issue     = w_issue;
    assign hz.id_stall     = w_stall;
    assign hz.id_bubble    = w_bubble;
    assign hz.busy         = w_busy;
    assign hz.sb_err       = w_sb_err;
    assign hz.stall_cycles = r_stall_cycles;
    assign hz.stall_events = r_stall_events;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_hazard_ctrl
//  Purpose  : Randomized self-checking bench for id_hazard_ctrl against a
//             behavioural scoreboard/counter model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

    localparam int c_PERF_W  = 4;
    localparam int c_CNT_MAX = 3;
    localparam int c_PERF_MX = 15;
    localparam int c_CYCLES  = 4000;

    logic clk;
    logic reset;

    id_hazard_ctrl_if #(.PERF_W(c_PERF_W)) hz_if ();

    id_hazard_ctrl #(
        .CNT_W  (2),
        .PERF_W (c_PERF_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_cnt[8];
    bit m_err;
    bit m_in_stall;
    int m_cycles;
    int m_events;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_err      = 1'b0;
        m_in_stall = 1'b0;
        m_cycles   = 0;
        m_events   = 0;
    endtask

    task automatic drive_idle();
        hz_if.id_valid    = 1'b0;
        hz_if.src1        = 3'd0;
        hz_if.src1_used   = 1'b0;
        hz_if.src2        = 3'd0;
        hz_if.src2_used   = 1'b0;
        hz_if.dest        = 3'd0;
        hz_if.dest_used   = 1'b0;
        hz_if.trapsel     = 1'b0;
        hz_if.flush       = 1'b0;
        hz_if.pipe_freeze = 1'b0;
        hz_if.wb_load     = 1'b0;
        hz_if.wb_dest     = 3'd0;
    endtask

    task automatic drive_random();
        int pick;
        hz_if.id_valid    = ($urandom_range(0, 9) < 8);
        hz_if.src1        = 3'($urandom_range(0, 7));
        hz_if.src1_used   = ($urandom_range(0, 3) != 0);
        hz_if.src2        = 3'($urandom_range(0, 7));
        hz_if.src2_used   = ($urandom_range(0, 1) != 0);
        // Few destinations so counters reach their limit now and then.
        hz_if.dest        = 3'($urandom_range(0, 3));
        hz_if.dest_used   = ($urandom_range(0, 3) != 0);
        hz_if.trapsel     = ($urandom_range(0, 7) == 0);
        hz_if.flush       = ($urandom_range(0, 9) == 0);
        hz_if.pipe_freeze = ($urandom_range(0, 9) == 0);
        hz_if.wb_load     = ($urandom_range(0, 9) < 4);
        hz_if.wb_dest     = 3'($urandom_range(0, 7));
        // Mostly retire a really pending write; occasionally an underflow.
        if ($urandom_range(0, 19) != 0) begin
            pick = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
                if (m_cnt[(pick + k) % 8] != 0) begin
                    hz_if.wb_dest = 3'((pick + k) % 8);
                    break;
                end
            end
        end
        reset = ($urandom_range(0, 199) == 0);
    endtask

    // Check the DUT in the current cycle against the model, then advance the
    // model by what the coming clock edge does.
    task automatic check_and_step();
        int  ed;
        bit  hz;
        bit  e_issue, e_stall, e_bubble;
        logic [7:0] e_busy;

        ed = hz_if.trapsel ? 7 : int'(hz_if.dest);
        hz = hz_if.id_valid &&
             ((hz_if.src1_used && m_cnt[hz_if.src1] > 0) ||
              (hz_if.src2_used && m_cnt[hz_if.src2] > 0) ||
              (hz_if.dest_used && m_cnt[ed] == c_CNT_MAX));

        e_issue = 0; e_stall = 0; e_bubble = 0;
        if (hz_if.pipe_freeze) begin
            e_issue = 0;
        end else if (hz_if.flush) begin
            e_bubble = 1;
        end else if (hz) begin
            e_stall = 1; e_bubble = 1;
        end else begin
            e_issue = hz_if.id_valid;
        end

        for (int i = 0; i < 8; i++) e_busy[i] = (m_cnt[i] > 0);

        chk("id_issue",     32'(hz_if.id_issue),     32'(e_issue));
        chk("id_stall",     32'(hz_if.id_stall),     32'(e_stall));
        chk("id_bubble",    32'(hz_if.id_bubble),    32'(e_bubble));
        chk("busy",         32'(hz_if.busy),         32'(e_busy));
        chk("sb_err",       32'(hz_if.sb_err),       32'(m_err));
        chk("stall_cycles", 32'(hz_if.stall_cycles), 32'(m_cycles));
        chk("stall_events", 32'(hz_if.stall_events), 32'(m_events));

        if (reset) begin
            model_reset();
        end else begin
            if (e_stall) begin
                if (!m_in_stall) m_events = (m_events < c_PERF_MX) ? m_events + 1 : m_events;
                m_cycles = (m_cycles < c_PERF_MX) ? m_cycles + 1 : m_cycles;
            end
            if (!hz_if.pipe_freeze) m_in_stall = !hz_if.flush && hz;

            if (e_issue && hz_if.dest_used && hz_if.wb_load && int'(hz_if.wb_dest) == ed) begin
                // write-back and new writer on the same register cancel
            end else begin
                if (e_issue && hz_if.dest_used) begin
                    if (m_cnt[ed] == c_CNT_MAX) m_err = 1'b1;
                    else m_cnt[ed]++;
                end
                if (hz_if.wb_load) begin
                    if (m_cnt[hz_if.wb_dest] == 0) m_err = 1'b1;
                    else m_cnt[hz_if.wb_dest]--;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hz_if.id_valid  = 1'b1;
        hz_if.src1      = 3'd2;
        hz_if.src1_used = 1'b1;
        #1;
        check_and_step();

        for (int c = 0; c < c_CYCLES; c++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_and_step();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
